hazard_ctrl: RTL and testbench

- Central hazard sequencer for the 5-stage core; drives stall, branch_flush and jal_flush into fetch/decode/execute/mem.
- Detects load-use hazards between decode and execute, holds the pipe during data-cache misses, and stretches redirect flushes from mem over a programmable number of cycles.
- Sits beside the pipeline; all requests come from stage output registers, all commands go to stage next-state logic.

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use stalls, d-cache miss holds and multi-cycle redirect flushes.
// Optional performance counters are compiled in with `define HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES     = 2,
    parameter int JAL_FLUSH_CYCLES = 1,
    parameter int MISS_TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  dec_reg1,
    input  logic [4:0]  dec_reg2,
    input  logic        dec_use1,
    input  logic        dec_use2,
    input  logic        ex_loadF,
    input  logic [4:0]  ex_regDF,
    input  logic        mem_branch_cond,
    input  logic        mem_jal,
    input  logic        mem_access,
    input  logic        dcache_hit,
    input  logic        dcache_resp_valid,
    output logic        stall,
    output logic        branch_flush,
    output logic        jal_flush,
    output logic        miss_err,
    output logic [1:0]  state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_misses
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MISS   = 2'd1,
        BFLUSH = 2'd2,
        JFLUSH = 2'd3
    } state_t;

    localparam logic [2:0] BR_RELOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] JAL_RELOAD = 3'(JAL_FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MISS_TIMEOUT);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [7:0] tcnt, tcnt_nxt;
    logic       miss_err_q;
    logic       load_use;
    logic       redirect;
    logic       enter_miss;

    assign load_use = ex_loadF && (ex_regDF != 5'd0) &&
                      ((dec_use1 && (dec_reg1 == ex_regDF)) ||
                       (dec_use2 && (dec_reg2 == ex_regDF)));

    assign miss_err = miss_err_q || ((state == MISS) && (tcnt == TIMEOUT));
    assign state_o  = state;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
        state_nxt    = state;
        cnt_nxt      = cnt;
        tcnt_nxt     = tcnt;
        stall        = 1'b0;
        branch_flush = 1'b0;
        jal_flush    = 1'b0;
        redirect     = 1'b0;
        enter_miss   = 1'b0;

        if (state == MISS) begin
            // The entry cycle (tcnt==0) cannot carry the refill for this miss.
            if (dcache_resp_valid && (tcnt != 8'd0)) begin
                state_nxt = RUN;
            end else begin
                stall = 1'b1;
                if (tcnt != TIMEOUT) tcnt_nxt = tcnt + 8'd1;
            end
        end else if (mem_jal) begin
            jal_flush = 1'b1;
            redirect  = 1'b1;
            cnt_nxt   = JAL_RELOAD;
            state_nxt = (JAL_FLUSH_CYCLES > 1) ? JFLUSH : RUN;
        end else if (mem_branch_cond) begin
            branch_flush = 1'b1;
            redirect     = 1'b1;
            cnt_nxt      = BR_RELOAD;
            state_nxt    = (FLUSH_CYCLES > 1) ? BFLUSH : RUN;
        end else if (state == BFLUSH || state == JFLUSH) begin
            branch_flush = (state == BFLUSH);
            jal_flush    = (state == JFLUSH);
            cnt_nxt      = cnt - 3'd1;
            if (cnt == 3'd1) state_nxt = RUN;
        end else if (mem_access && !dcache_hit) begin
            stall      = 1'b1;
            enter_miss = 1'b1;
            tcnt_nxt   = 8'd0;
            state_nxt  = MISS;
        end else if (load_use) begin
            stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            state      <= RUN;
            cnt        <= 3'd0;
            tcnt       <= 8'd0;
            miss_err_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            tcnt       <= tcnt_nxt;
            miss_err_q <= miss_err;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flushes      <= 32'd0;
            perf_misses       <= 32'd0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + {31'd0, stall};
            perf_flushes      <= perf_flushes + {31'd0, redirect};
            perf_misses       <= perf_misses + {31'd0, enter_miss};
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table plus random stimulus checked against a cycle-level reference model.
// Two instances with different flush lengths share the stimulus.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic       jal;
        logic       acc;
        logic       hit;
        logic       resp;
    } in_t;

    typedef struct {
        in_t        in;
        logic [5:0] exp;  // {stall, branch_flush, jal_flush, miss_err, state[1:0]}
    } vec_t;

    // Reference: mode 0 = running, 1 = waiting on refill, 2 = flushing (kind 2 branch / 3 jump)
    typedef struct {
        int          mode;
        int          kind;
        int          left;
        int          age;
        bit          err;
        int unsigned pstall;
        int unsigned pfl;
        int unsigned pmiss;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, dec_use1, dec_use2, ex_loadF, mem_branch_cond, mem_jal, mem_access, dcache_hit, dcache_resp_valid;
    logic [4:0] dec_reg1, dec_reg2, ex_regDF;
    logic       stall1, bf1, jf1, err1, stall2, bf2, jf2, err2;
    logic [1:0] st1, st2;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ps1, pf1, pm1, ps2, pf2, pm2;
`endif

    hazard_ctrl #(.FLUSH_CYCLES(2), .JAL_FLUSH_CYCLES(1), .MISS_TIMEOUT(8)) u_dut1 (
        .clk(clk), .rst(rst), .dec_reg1(dec_reg1), .dec_reg2(dec_reg2), .dec_use1(dec_use1), .dec_use2(dec_use2),
        .ex_loadF(ex_loadF), .ex_regDF(ex_regDF), .mem_branch_cond(mem_branch_cond), .mem_jal(mem_jal),
        .mem_access(mem_access), .dcache_hit(dcache_hit), .dcache_resp_valid(dcache_resp_valid),
        .stall(stall1), .branch_flush(bf1), .jal_flush(jf1), .miss_err(err1), .state_o(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(ps1), .perf_flushes(pf1), .perf_misses(pm1)
`endif
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .JAL_FLUSH_CYCLES(3), .MISS_TIMEOUT(8)) u_dut2 (
        .clk(clk), .rst(rst), .dec_reg1(dec_reg1), .dec_reg2(dec_reg2), .dec_use1(dec_use1), .dec_use2(dec_use2),
        .ex_loadF(ex_loadF), .ex_regDF(ex_regDF), .mem_branch_cond(mem_branch_cond), .mem_jal(mem_jal),
        .mem_access(mem_access), .dcache_hit(dcache_hit), .dcache_resp_valid(dcache_resp_valid),
        .stall(stall2), .branch_flush(bf2), .jal_flush(jf2), .miss_err(err2), .state_o(st2)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(ps2), .perf_flushes(pf2), .perf_misses(pm2)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    mdl_t m1, m2;
    vec_t vecs[$];
    int   perf_mark;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m = '{mode: 0, kind: 0, left: 0, age: 0, err: 1'b0, pstall: 0, pfl: 0, pmiss: 0};
        return m;
    endfunction

    function automatic void mdl_step(input mdl_t m, input in_t i, input int f, input int j, input int t,
                                     output logic [5:0] o, output mdl_t nm);
        logic s, b, jf, e, lu;
        int   st;
        nm = m;
        s  = 1'b0; b = 1'b0; jf = 1'b0;
        st = (m.mode == 2) ? m.kind : m.mode;
        e  = m.err || (m.mode == 1 && m.age >= t);
        lu = i.ld && i.rd != 0 && ((i.u1 && i.r1 == i.rd) || (i.u2 && i.r2 == i.rd));
        if (m.mode == 1) begin
            if (i.resp && m.age > 0) nm.mode = 0;
            else begin s = 1'b1; nm.age = m.age + 1; end
        end else if (i.jal) begin
            jf = 1'b1; nm.pfl++; nm.kind = 3; nm.left = j - 1; nm.mode = (j > 1) ? 2 : 0;
        end else if (i.br) begin
            b = 1'b1; nm.pfl++; nm.kind = 2; nm.left = f - 1; nm.mode = (f > 1) ? 2 : 0;
        end else if (m.mode == 2) begin
            if (m.kind == 2) b = 1'b1; else jf = 1'b1;
            nm.left = m.left - 1;
            if (nm.left == 0) nm.mode = 0;
        end else if (i.acc && !i.hit) begin
            s = 1'b1; nm.mode = 1; nm.age = 0; nm.pmiss++;
        end else if (lu) begin
            s = 1'b1;
        end
        nm.err = e;
        if (s) nm.pstall++;
        o = {s, b, jf, e, 2'(st)};
        if (i.rst) nm = mdl_reset();
    endfunction

    task automatic apply(input in_t v, input bit has_exp, input logic [5:0] exp);
        logic [5:0] o1, o2;
        mdl_t       n1, n2;
        rst = v.rst; dec_reg1 = v.r1; dec_reg2 = v.r2; dec_use1 = v.u1; dec_use2 = v.u2;
        ex_loadF = v.ld; ex_regDF = v.rd; mem_branch_cond = v.br; mem_jal = v.jal;
        mem_access = v.acc; dcache_hit = v.hit; dcache_resp_valid = v.resp;
        #2;
        mdl_step(m1, v, 2, 1, 8, o1, n1);
        mdl_step(m2, v, 1, 3, 8, o2, n2);
        check("dut1_vs_model", {58'd0, stall1, bf1, jf1, err1, st1}, {58'd0, o1});
        check("dut2_vs_model", {58'd0, stall2, bf2, jf2, err2, st2}, {58'd0, o2});
        if (has_exp) check("vector", {58'd0, stall1, bf1, jf1, err1, st1}, {58'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
        check("perf1", {ps1, pf1 ^ pm1}, {m1.pstall, m1.pfl ^ m1.pmiss});
        check("perf2", {ps2, pf2 ^ pm2}, {m2.pstall, m2.pfl ^ m2.pmiss});
`endif
        @(posedge clk);
        m1 = n1;
        m2 = n2;
        #1;
    endtask

    function automatic logic [5:0] ex(bit s, bit b, bit j, bit e, logic [1:0] st);
        return {s, b, j, e, st};
    endfunction

    task automatic add(input in_t v, input logic [5:0] e);
        vec_t x;
        x.in  = v;
        x.exp = e;
        vecs.push_back(x);
    endtask

    initial begin
        in_t v, lu, idle, miss;

        idle = '0;
        lu = '0; lu.ld = 1; lu.rd = 5; lu.r2 = 5; lu.u2 = 1;
        miss = '0; miss.acc = 1;

        // Directed table for u_dut1 (branch flush 2 cycles, jump flush 1 cycle, timeout 8)
        add(lu, ex(1, 0, 0, 0, 0));
        add(idle, ex(0, 0, 0, 0, 0));
        v = lu; v.rd = 0; v.r2 = 0; add(v, ex(0, 0, 0, 0, 0));
        v = '0; v.ld = 1; v.rd = 7; v.r1 = 7; add(v, ex(0, 0, 0, 0, 0));
        v.u1 = 1; add(v, ex(1, 0, 0, 0, 0));
        add(miss, ex(1, 0, 0, 0, 0));
        v = '0; v.resp = 1; add(v, ex(1, 0, 0, 0, 1));
        add(idle, ex(1, 0, 0, 0, 1));
        add(idle, ex(1, 0, 0, 0, 1));
        add(v, ex(0, 0, 0, 0, 1));
        v = miss; v.hit = 1; add(v, ex(0, 0, 0, 0, 0));
        v = lu; v.br = 1; add(v, ex(0, 1, 0, 0, 0));
        add(lu, ex(0, 1, 0, 0, 2));
        perf_mark = vecs.size();
        add(idle, ex(0, 0, 0, 0, 0));
        v = '0; v.jal = 1; v.br = 1; add(v, ex(0, 0, 1, 0, 0));
        v = '0; v.br = 1; add(v, ex(0, 1, 0, 0, 0));
        add(v, ex(0, 1, 0, 0, 2));
        add(idle, ex(0, 1, 0, 0, 2));
        add(idle, ex(0, 0, 0, 0, 0));
        add(v, ex(0, 1, 0, 0, 0));
        v = '0; v.jal = 1; add(v, ex(0, 0, 1, 0, 2));
        add(idle, ex(0, 0, 0, 0, 0));
        v = lu; v.acc = 1; add(v, ex(1, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) add(idle, ex(1, 0, 0, 0, 1));
        add(idle, ex(1, 0, 0, 1, 1));
        v = '0; v.resp = 1; add(v, ex(0, 0, 0, 1, 1));
        add(idle, ex(0, 0, 0, 1, 0));
        add(miss, ex(1, 0, 0, 1, 0));
        add(idle, ex(1, 0, 0, 1, 1));
        v = '0; v.rst = 1; add(v, ex(1, 0, 0, 1, 1));
        add(idle, ex(0, 0, 0, 0, 0));

        v = '0; v.rst = 1;
        rst = 1; dec_reg1 = 0; dec_reg2 = 0; dec_use1 = 0; dec_use2 = 0; ex_loadF = 0; ex_regDF = 0;
        mem_branch_cond = 0; mem_jal = 0; mem_access = 0; dcache_hit = 0; dcache_resp_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        m1 = mdl_reset();
        m2 = mdl_reset();

        for (int k = 0; k < vecs.size(); k++) begin
`ifdef HAZARD_PERF_CNT_EN
            if (k == perf_mark) begin
                check("perf_stall_cycles", 64'(ps1), 64'd6);
                check("perf_flushes", 64'(pf1), 64'd1);
                check("perf_misses", 64'(pm1), 64'd1);
            end
`endif
            apply(vecs[k].in, 1'b1, vecs[k].exp);
        end

        for (int k = 0; k < 4000; k++) begin
            v      = '0;
            v.rst  = ($urandom_range(0, 199) == 0);
            v.r1   = 5'($urandom_range(0, 3));
            v.r2   = 5'($urandom_range(0, 3));
            v.u1   = 1'($urandom);
            v.u2   = 1'($urandom);
            v.ld   = 1'($urandom);
            v.rd   = 5'($urandom_range(0, 3));
            v.br   = ($urandom_range(0, 7) == 0);
            v.jal  = ($urandom_range(0, 11) == 0);
            v.acc  = ($urandom_range(0, 2) == 0);
            v.hit  = ($urandom_range(0, 2) != 0);
            v.resp = ($urandom_range(0, 6) == 0);
            apply(v, 1'b0, 6'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
